multicycle_main_controller: RTL and testbench
=============================================

Name: multicycle_main_controller

Overview:
- Multicycle RV32I main control FSM. Fetches an instruction over a req/ack instruction-memory handshake and latches it in the instruction register.
- Decodes the opcode and sequences the datapath through EXEC, MEM and WB.
- Drives the `alu_op`/`branch`/`funct3`/`funct7` bundle consumed by the ALU controller, and is the producer end of that interface.
- Also drives memory handshakes, register-file write and PC update.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles waited for any ack before entering TRAP. Legal range 1..65535.
- RESET_TO_FETCH, 1, 1 = leave reset directly into FETCH; 0 = wait in IDLE until `start`.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  leave IDLE (ignored when RESET_TO_FETCH=1)
- imem_ack  input  1  instruction-memory data valid
- imem_rdata  input  32  instruction word
- dmem_ack  input  1  data-memory access complete
- branch_taken  input  1  ALU comparison result, valid in EXEC
- imem_req  output  1  instruction fetch request
- dmem_req  output  1  data access request
- mem_write  output  1  1 = store, 0 = load; valid with dmem_req
- ir_write  output  1  latch instruction register
- pc_write  output  1  update PC
- pc_src  output  2  00 = pc+4, 01 = branch/JAL target, 10 = JALR target
- alu_op  output  3  000 ld/st, 001 branch, 010 R, 011 I-arith, 100 JAL, 101 JALR, 110 LUI, 111 AUIPC
- branch  output  1  branch qualifier to ALU controller
- alu_src  output  1  1 = immediate operand B
- funct3  output  3  IR[14:12]
- funct7  output  7  IR[31:25]
- reg_write  output  1  register-file write enable
- wb_sel  output  2  00 = ALU, 01 = memory, 10 = pc+4
- illegal  output  1  sticky trap flag
- retired  output  1  one-cycle pulse per completed instruction

Behaviour:
- Reset (async, rst_n=0):
  - State goes to FETCH (RESET_TO_FETCH=1) or IDLE (RESET_TO_FETCH=0).
  - IR = 32'h00000013 (NOP), timeout counter = 0.
  - All outputs 0, except `funct3`/`funct7`, which reflect the IR.
  - Reset mid-transaction drops `imem_req`/`dmem_req` immediately; a late ack after reset is ignored.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Output timing: outputs are Moore, decoded from state plus the registered IR. Exceptions: `ir_write` and `pc_write` in FETCH, and `pc_write` in EXEC, are qualified by the inputs named below.
- IDLE: all outputs 0; `start` -> FETCH.
- FETCH:
  - `imem_req`=1 and held until ack.
  - `imem_ack` sampled at the rising edge. If high, assert `ir_write`=1 and `pc_write`=1 with `pc_src`=00 that cycle, IR <= `imem_rdata`, then -> DECODE.
  - Zero-wait: an ack in the first FETCH cycle is legal.
- DECODE (1 cycle):
  - Opcode IR[6:0] classified.
  - Legal opcodes are 0000011, 0100011, 0110011, 0010011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode -> TRAP; otherwise -> EXEC.
- EXEC (1 cycle):
  - `alu_op` per class; `branch`=1 only for 1100011.
  - `alu_src`=1 for load, store, I-arith and JALR.
  - Branch: `pc_write`=`branch_taken`, `pc_src`=01, `retired`=1, -> FETCH.
  - JAL: `pc_write`=1, `pc_src`=01, -> WB. JALR: `pc_write`=1, `pc_src`=10, -> WB.
  - Load/store -> MEM. All others -> WB.
- MEM:
  - `dmem_req`=1; `alu_op`=000 and `alu_src`=1 held so the address stays stable.
  - `mem_write`=1 for a store.
  - On `dmem_ack`: load -> WB; store pulses `retired` and -> FETCH.
- WB (1 cycle):
  - `reg_write`=1, except when IR[11:7]==0, where `reg_write`=0 but the instruction still retires.
  - `wb_sel`: 01 load, 10 JAL/JALR, 00 otherwise.
  - `retired`=1; -> FETCH.
- TRAP:
  - `illegal`=1, all other outputs 0.
  - Held until reset.
- Timeout:
  - Counter increments each cycle in FETCH/MEM while ack is low, and clears on state exit.
  - When the counter reaches TIMEOUT_CYCLES with ack still low -> TRAP.
  - An ack arriving in the same cycle as the terminal count wins.
- Cycle counts (zero-wait acks): branch 3, store 4, R/I/LUI/AUIPC/JAL/JALR 4, load 5.
- The `alu_op` encoding matches the ALU controller exactly; `funct3`/`funct7` are stable from DECODE through WB.

Decomposition:
- Shared package `riscv_ctrl_pkg`:
  - opcode constants;
  - the `alu_op_t` enum (8 codes above);
  - `pc_src_t` and `wb_sel_t` enums;
  - the `ctrl_state_t` enum.
- One sub-module, `opcode_classifier`: combinational IR[6:0] -> class one-hot plus a legal flag. It is reused by a future pipelined decoder.

Test Plan:
- ADD x3,x1,x2 (32'h002081B3), zero-wait acks -> FETCH, DECODE, EXEC, WB.
  - `alu_op`=010 and `funct7`=0 in EXEC.
  - `reg_write`=1, `wb_sel`=00 in WB.
  - `retired` pulse at cycle 4.
- LW x5,8(x1) (32'h0080A283), `dmem_ack` delayed 3 cycles -> `dmem_req` high for 4 cycles with `mem_write`=0; WB `wb_sel`=01; total 8 cycles.
- BNE taken (32'h00209463), `branch_taken`=1 -> EXEC shows `branch`=1, `alu_op`=001, `funct3`=001, `pc_write`=1, `pc_src`=01; next state FETCH; no `reg_write`.
- Illegal opcode 32'hFFFFFFFF -> DECODE then TRAP; `illegal`=1 stays set for 100 cycles; `imem_req` stays 0.
- TIMEOUT_CYCLES=4 with `imem_ack` never asserted -> TRAP entered after 4 wait cycles. Repeating with the ack on the 4th cycle -> DECODE, no trap.
- Reset asserted in MEM of SW (32'h0020A023) with `dmem_ack` pending -> `dmem_req` drops asynchronously; after release, FETCH with IR=NOP and all outputs 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Brief    : Opcode constants and shared control-path types for RV32I.
// Revision : 1.0
// ============================================================================
package riscv_ctrl_pkg;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_LDST   = 3'b000,
        ALU_BRANCH = 3'b001,
        ALU_R      = 3'b010,
        ALU_I      = 3'b011,
        ALU_JAL    = 3'b100,
        ALU_JALR   = 3'b101,
        ALU_LUI    = 3'b110,
        ALU_AUIPC  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_JALR   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } ctrl_state_t;

    // One-hot instruction class; all-zero means the opcode is not recognised.
    typedef struct packed {
        logic load;
        logic store;
        logic rtype;
        logic itype;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
    } op_class_t;

    function automatic alu_op_t class_to_alu_op(input op_class_t c);
        alu_op_t op;
        op = ALU_LDST;
        if (c.branch)     op = ALU_BRANCH;
        else if (c.rtype) op = ALU_R;
        else if (c.itype) op = ALU_I;
        else if (c.jal)   op = ALU_JAL;
        else if (c.jalr)  op = ALU_JALR;
        else if (c.lui)   op = ALU_LUI;
        else if (c.auipc) op = ALU_AUIPC;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_classifier.sv
`default_nettype none
// ============================================================================
// Module   : opcode_classifier
// Brief    : Combinational RV32I opcode -> one-hot class plus legal flag.
// Revision : 1.0
// ============================================================================
module opcode_classifier
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            c_op_load:   o_class.load   = 1'b1;
            c_op_store:  o_class.store  = 1'b1;
            c_op_rtype:  o_class.rtype  = 1'b1;
            c_op_itype:  o_class.itype  = 1'b1;
            c_op_branch: o_class.branch = 1'b1;
            c_op_jal:    o_class.jal    = 1'b1;
            c_op_jalr:   o_class.jalr   = 1'b1;
            c_op_lui:    o_class.lui    = 1'b1;
            c_op_auipc:  o_class.auipc  = 1'b1;
            default:     o_class        = '0;
        endcase
    end

    assign o_legal = |o_class;

endmodule
`default_nettype wire

// File: rtl/multicycle_main_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_controller
// Brief    : Multicycle RV32I main control FSM (fetch/decode/exec/mem/wb).
// Revision : 1.0
// ============================================================================
module multicycle_main_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RESET_TO_FETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic        branch,
    output logic        alu_src,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        retired
);

    localparam ctrl_state_t c_reset_state  = RESET_TO_FETCH ? S_FETCH : S_IDLE;
    localparam logic [31:0] c_nop          = 32'h0000_0013;
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    ctrl_state_t r_state;
    ctrl_state_t w_next;
    logic [31:0] r_ir;
    logic [15:0] r_cnt;
    op_class_t   w_class;
    logic        w_legal;
    logic        w_waiting;
    logic        w_ack;
    logic        w_expired;
    logic        w_unused;

    opcode_classifier u_classifier (
        .i_opcode (r_ir[6:0]),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ack     = (r_state == S_FETCH) ? imem_ack : dmem_ack;
    // An ack on the terminal-count cycle still wins over the timeout.
    assign w_expired = w_waiting && !w_ack && (r_cnt == c_timeout_last);

    assign funct3   = r_ir[14:12];
    assign funct7   = r_ir[31:25];
    assign w_unused = ^r_ir[24:15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_reset_state;
            r_ir    <= c_nop;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && imem_ack) begin
                r_ir <= imem_rdata;
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_waiting && !w_ack) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS4;
        alu_op    = ALU_LDST;
        branch    = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        illegal   = 1'b0;
        retired   = 1'b0;
        // Outputs are forced low while reset is held so requests drop at once.
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_next = S_FETCH;
                end
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = S_DECODE;
                    end else if (w_expired) begin
                        w_next = S_TRAP;
                    end
                end
                S_DECODE: begin
                    w_next = w_legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    alu_op  = class_to_alu_op(w_class);
                    branch  = w_class.branch;
                    alu_src = w_class.load | w_class.store | w_class.itype | w_class.jalr;
                    if (w_class.branch) begin
                        pc_write = branch_taken;
                        pc_src   = PC_TARGET;
                        retired  = 1'b1;
                        w_next   = S_FETCH;
                    end else if (w_class.jal) begin
                        pc_write = 1'b1;
                        pc_src   = PC_TARGET;
                        w_next   = S_WB;
                    end else if (w_class.jalr) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JALR;
                        w_next   = S_WB;
                    end else if (w_class.load || w_class.store) begin
                        w_next = S_MEM;
                    end else begin
                        w_next = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    alu_src   = 1'b1;
                    mem_write = w_class.store;
                    if (dmem_ack) begin
                        if (w_class.store) begin
                            retired = 1'b1;
                            w_next  = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end else if (w_expired) begin
                        w_next = S_TRAP;
                    end
                end
                S_WB: begin
                    reg_write = |r_ir[11:7];
                    if (w_class.load)                    wb_sel = WB_MEM;
                    else if (w_class.jal || w_class.jalr) wb_sel = WB_PC4;
                    retired = 1'b1;
                    w_next  = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    w_next = c_reset_state;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_main_controller
// Brief    : Self-checking bench: directed + random instruction sequences.
// Revision : 1.0
// ============================================================================
module tb_multicycle_main_controller;

    localparam int          TMO   = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          K_BAD = 9;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       branch;
        logic       alu_src;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       retired;
    } outv_t;

    logic        clk, rst_n, start, imem_ack, dmem_ack, branch_taken;
    logic [31:0] imem_rdata;
    logic        imem_req, dmem_req, mem_write, ir_write, pc_write, branch, alu_src;
    logic        reg_write, illegal, retired;
    logic [1:0]  pc_src, wb_sel;
    logic [2:0]  alu_op, funct3;
    logic [6:0]  funct7;
    outv_t       obs;
    logic [31:0] m_ir;
    int          n_checks = 0;
    int          n_errors = 0;

    // Class order: load, store, R, I, branch, JAL, JALR, LUI, AUIPC.
    logic [6:0] op_tab  [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [2:0] alu_tab [9] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    multicycle_main_controller #(.TIMEOUT_CYCLES(TMO), .RESET_TO_FETCH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_ack(dmem_ack), .branch_taken(branch_taken),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_op(alu_op), .branch(branch), .alu_src(alu_src),
        .funct3(funct3), .funct7(funct7), .reg_write(reg_write),
        .wb_sel(wb_sel), .illegal(illegal), .retired(retired)
    );

    assign obs = {imem_req, dmem_req, mem_write, ir_write, pc_write, pc_src, alu_op,
                  branch, alu_src, funct3, funct7, reg_write, wb_sel, illegal, retired};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int kind_of(input logic [6:0] op);
        for (int i = 0; i < 9; i++) begin
            if (op_tab[i] == op) return i;
        end
        return K_BAD;
    endfunction

    function automatic outv_t base();
        outv_t v;
        v        = '0;
        v.funct3 = m_ir[14:12];
        v.funct7 = m_ir[31:25];
        return v;
    endfunction

    task automatic check(input string tag, input outv_t e, input outv_t c);
        logic [26:0] o_m, e_m;
        o_m = obs & c;
        e_m = e & c;
        n_checks++;
        assert (o_m === e_m) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h care=%h", tag, o_m, e_m, c);
        end
    endtask

    // Drive one instruction through every phase, checking each cycle.
    // fw/mw: wait cycles before ack; -1 = never ack; mw=-2 = stop after one MEM cycle.
    task automatic run_instr(input logic [31:0] word, input int fw, input int mw,
                             input logic taken, input string tag);
        outv_t e, c;
        int    k, nf, nm;
        k  = kind_of(word[6:0]);
        nf = (fw < 0) ? TMO : fw + 1;
        for (int i = 0; i < nf; i++) begin
            imem_ack   = (fw >= 0) && (i == fw);
            imem_rdata = imem_ack ? word : $urandom;
            #1;
            e = base(); c = '1;
            e.imem_req = 1'b1;
            e.ir_write = imem_ack;
            e.pc_write = imem_ack;
            if (!imem_ack) c.pc_src = '0;
            check({tag, "/fetch"}, e, c);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        if (fw < 0) return;
        m_ir = word;
        #1;
        e = base(); c = '1;
        c.pc_src = '0; c.alu_op = '0; c.branch = 1'b0; c.alu_src = 1'b0; c.wb_sel = '0;
        check({tag, "/decode"}, e, c);
        @(negedge clk);
        if (k == K_BAD) return;

        branch_taken = taken;
        #1;
        e = base(); c = '1;
        c.wb_sel  = '0; c.pc_src = '0;
        e.alu_op  = alu_tab[k];
        e.branch  = (k == 4);
        e.alu_src = (k == 0) || (k == 1) || (k == 3) || (k == 6);
        if (k == 4) begin
            e.pc_write = taken; e.pc_src = 2'b01; c.pc_src = '1; e.retired = 1'b1;
        end else if (k == 5) begin
            e.pc_write = 1'b1;  e.pc_src = 2'b01; c.pc_src = '1;
        end else if (k == 6) begin
            e.pc_write = 1'b1;  e.pc_src = 2'b10; c.pc_src = '1;
        end
        check({tag, "/exec"}, e, c);
        @(negedge clk);
        branch_taken = 1'($urandom_range(0, 1));
        if (k == 4) return;

        if (k == 0 || k == 1) begin
            nm = (mw >= 0) ? mw + 1 : ((mw == -1) ? TMO : 1);
            for (int i = 0; i < nm; i++) begin
                dmem_ack = (mw >= 0) && (i == mw);
                #1;
                e = base(); c = '1;
                c.pc_src = '0; c.branch = 1'b0; c.wb_sel = '0;
                e.dmem_req  = 1'b1;
                e.mem_write = (k == 1);
                e.alu_src   = 1'b1;
                e.retired   = (k == 1) && dmem_ack;
                check({tag, "/mem"}, e, c);
                @(negedge clk);
            end
            dmem_ack = 1'b0;
            if (mw < 0 || k == 1) return;
        end

        #1;
        e = base(); c = '1;
        c.alu_op = '0; c.alu_src = 1'b0; c.branch = 1'b0; c.pc_src = '0;
        e.reg_write = (word[11:7] != 5'd0);
        e.wb_sel    = (k == 0) ? 2'b01 : ((k == 5 || k == 6) ? 2'b10 : 2'b00);
        e.retired   = 1'b1;
        check({tag, "/wb"}, e, c);
        @(negedge clk);
    endtask

    task automatic trap_check(input int n, input string tag);
        outv_t e, c;
        for (int i = 0; i < n; i++) begin
            imem_ack     = 1'($urandom_range(0, 1));
            dmem_ack     = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            #1;
            e = '0; e.illegal = 1'b1;
            c = '1; c.funct3 = '0; c.funct7 = '0;
            check(tag, e, c);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        m_ir  = NOP;
        #1;
        check(tag, base(), '1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        branch_taken = 1'b0; imem_rdata = '0; m_ir = NOP;
        repeat (2) @(negedge clk);
        #1;
        check("reset", base(), '1);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(32'h002081B3, 0, 0, 1'b0, "add");
        run_instr(32'h0080A283, 0, 3, 1'b0, "lw_wait3");
        run_instr(32'h00209463, 0, 0, 1'b1, "bne_taken");
        run_instr(32'h00209463, 2, 0, 1'b0, "bne_not_taken");
        run_instr(32'h0000006F, 0, 0, 1'b0, "jal_rd0");

        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            int          kk;
            kk      = int'($urandom_range(0, 8));
            w       = $urandom;
            w[6:0]  = op_tab[kk];
            if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
            run_instr(w, int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)),
                      1'($urandom_range(0, 1)), "rand");
        end

        run_instr(32'h002081B3, TMO - 1, 0, 1'b0, "fetch_ack_last");
        run_instr(32'h002081B3, -1, 0, 1'b0, "fetch_timeout");
        trap_check(5, "fetch_timeout/trap");
        do_reset("reset_after_fetch_trap");

        run_instr(32'h0080A283, 0, -1, 1'b0, "mem_timeout");
        trap_check(5, "mem_timeout/trap");
        do_reset("reset_after_mem_trap");

        run_instr(32'h0020A023, 1, -2, 1'b0, "sw_rst");
        #2;
        rst_n = 1'b0;
        m_ir  = NOP;
        #1;
        check("sw_rst/async_drop", base(), '1);
        dmem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(32'h00108093, 0, 0, 1'b0, "post_rst_addi");
        dmem_ack = 1'b0;

        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, "illegal");
        trap_check(100, "illegal/trap");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
